// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: payload plus valid, with stall hold,
// bubble insertion, deferred flush and saturating bubble/hold performance counters.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 140,
  parameter int                 STALL_W   = 6,
  parameter int                 STAGE_IDX = 2,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_in,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [1:0]         state_out,
  output logic [CNT_W-1:0]   bubble_cnt_out,
  output logic [CNT_W-1:0]   hold_cnt_out
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              up_stall;
  logic              dn_stall;
  logic              unused_stall;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  action_e           state_q, state_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              flush_latched_q, flush_latched_d;

  assign up_stall     = stall[STAGE_IDX];
  assign dn_stall     = stall[STAGE_IDX+1];
  assign unused_stall = ^stall;

  // Downstream stall dominates; an upstream-running/downstream-stalled vector is also a HOLD.
  always_comb begin
    valid_d         = valid_q;
    data_d          = data_q;
    state_d         = state_q;
    bubble_cnt_d    = bubble_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    flush_latched_d = flush_latched_q;
    if (dn_stall) begin
      state_d         = ACT_HOLD;
      hold_cnt_d      = sat_inc(hold_cnt_q);
      flush_latched_d = flush_latched_q | flush_in;
    end else if (flush_in || flush_latched_q) begin
      state_d         = ACT_FLUSH;
      valid_d         = 1'b0;
      data_d          = NOP_VALUE;
      hold_cnt_d      = '0;
      flush_latched_d = 1'b0;
    end else if (up_stall) begin
      state_d      = ACT_BUBBLE;
      valid_d      = 1'b0;
      data_d       = NOP_VALUE;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
      hold_cnt_d   = '0;
    end else begin
      state_d    = ACT_LOAD;
      valid_d    = valid_in;
      data_d     = data_in;
      hold_cnt_d = '0;
    end
  end

  // Stage boundary: everything registered, reset discards any pending flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q         <= 1'b0;
      data_q          <= NOP_VALUE;
      state_q         <= ACT_FLUSH;
      bubble_cnt_q    <= '0;
      hold_cnt_q      <= '0;
      flush_latched_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      data_q          <= data_d;
      state_q         <= state_d;
      bubble_cnt_q    <= bubble_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      flush_latched_q <= flush_latched_d;
    end
  end

  assign valid_out      = valid_q;
  assign data_out       = data_q;
  assign state_out      = state_q;
  assign bubble_cnt_out = bubble_cnt_q;
  assign hold_cnt_out   = hold_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg: a default instance (CNT_W=16) and a
// CNT_W=2 instance share the stimulus; expectations are queued per step and checked after the edge.
module tb_pipe_stage_reg;
  localparam int DW = 140;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [5:0]    stall;
  logic          flush_in;
  logic          valid_in;
  logic [DW-1:0] data_in;

  logic          valid_out, valid_out_s;
  logic [DW-1:0] data_out, data_out_s;
  logic [1:0]    state_out, state_out_s;
  logic [15:0]   bubble_cnt_out, hold_cnt_out;
  logic [1:0]    bubble_cnt_s, hold_cnt_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [1:0]    st;
    int            b;
    int            h;
  } exp_t;
  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE_IDX(2), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall(stall), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out), .data_out(data_out),
    .state_out(state_out), .bubble_cnt_out(bubble_cnt_out), .hold_cnt_out(hold_cnt_out)
  );

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE_IDX(2), .CNT_W(2)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .stall(stall), .flush_in(flush_in),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out_s), .data_out(data_out_s),
    .state_out(state_out_s), .bubble_cnt_out(bubble_cnt_s), .hold_cnt_out(hold_cnt_s)
  );

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic step(input logic r, input logic [5:0] s, input logic f, input logic vi,
                      input logic [DW-1:0] di, input logic ev, input logic [DW-1:0] ed,
                      input logic [1:0] est, input int eb, input int eh);
    exp_t e;
    exp_t got;
    rst_in   = r;
    stall    = s;
    flush_in = f;
    valid_in = vi;
    data_in  = di;
    e.v = ev; e.d = ed; e.st = est; e.b = eb; e.h = eh;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = sb.pop_front();
      chk("valid",        DW'(valid_out),      DW'(got.v));
      chk("data",         data_out,            got.d);
      chk("state",        DW'(state_out),      DW'(got.st));
      chk("bubble_cnt",   DW'(bubble_cnt_out), DW'(got.b));
      chk("hold_cnt",     DW'(hold_cnt_out),   DW'(got.h));
      chk("s_valid",      DW'(valid_out_s),    DW'(got.v));
      chk("s_data",       data_out_s,          got.d);
      chk("s_state",      DW'(state_out_s),    DW'(got.st));
      chk("s_bubble_sat", DW'(bubble_cnt_s),   DW'(sat3(got.b)));
      chk("s_hold_sat",   DW'(hold_cnt_s),     DW'(sat3(got.h)));
    end
  endtask

  initial begin
    rst_in = 1'b1; stall = '0; flush_in = 1'b0; valid_in = 1'b0; data_in = '0;
    @(negedge clk_in);

    // reset ignores valid data on the inputs
    step(1, 6'b000000, 0, 1, 'hABC, 0, '0, 3, 0, 0);
    step(1, 6'b000000, 0, 1, 'hABC, 0, '0, 3, 0, 0);

    // load stream
    step(0, 6'b000000, 0, 1, 'h1, 1, 'h1, 0, 0, 0);
    step(0, 6'b000000, 0, 1, 'h2, 1, 'h2, 0, 0, 0);
    step(0, 6'b000000, 0, 1, 'h3, 1, 'h3, 0, 0, 0);

    // bubbles, then release
    step(0, 6'b000111, 0, 1, 'h4, 0, '0, 2, 1, 0);
    step(0, 6'b000111, 0, 1, 'h4, 0, '0, 2, 2, 0);
    step(0, 6'b000111, 0, 1, 'h4, 0, '0, 2, 3, 0);
    step(0, 6'b000000, 0, 1, 'h55, 1, 'h55, 0, 3, 0);

    // hold four cycles
    step(0, 6'b001111, 0, 1, 'h99, 1, 'h55, 1, 3, 1);
    step(0, 6'b001111, 0, 1, 'h99, 1, 'h55, 1, 3, 2);
    step(0, 6'b001111, 0, 1, 'h99, 1, 'h55, 1, 3, 3);
    step(0, 6'b001111, 0, 1, 'h99, 1, 'h55, 1, 3, 4);
    // release; payload loads even with valid_in low
    step(0, 6'b000000, 0, 0, 'h66, 0, 'h66, 0, 3, 0);

    // deferred flush during hold, second pulse absorbed
    step(0, 6'b001111, 0, 1, 'h11, 0, 'h66, 1, 3, 1);
    step(0, 6'b001111, 1, 1, 'h11, 0, 'h66, 1, 3, 2);
    step(0, 6'b001111, 0, 1, 'h11, 0, 'h66, 1, 3, 3);
    step(0, 6'b001111, 1, 1, 'h11, 0, 'h66, 1, 3, 4);
    step(0, 6'b000000, 0, 1, 'h77, 0, '0, 3, 3, 0);
    step(0, 6'b000000, 0, 1, 'h77, 1, 'h77, 0, 3, 0);

    // flush beats bubble: no bubble counted
    step(0, 6'b000111, 1, 1, 'h88, 0, '0, 3, 3, 0);

    // bubble counter saturation on the narrow instance
    step(0, 6'b000111, 0, 1, 'h88, 0, '0, 2, 4, 0);
    step(0, 6'b000111, 0, 1, 'h88, 0, '0, 2, 5, 0);
    step(0, 6'b000111, 0, 1, 'h88, 0, '0, 2, 6, 0);
    step(0, 6'b000111, 0, 1, 'h88, 0, '0, 2, 7, 0);
    step(0, 6'b000111, 0, 1, 'h88, 0, '0, 2, 8, 0);

    // illegal stall vector (up=0, dn=1) behaves as hold
    step(0, 6'b000000, 0, 1, 'h42, 1, 'h42, 0, 8, 0);
    step(0, 6'b001000, 0, 1, 'h43, 1, 'h42, 1, 8, 1);

    // reset during hold with a pending flush discards everything
    step(0, 6'b001111, 1, 1, 'h44, 1, 'h42, 1, 8, 2);
    step(1, 6'b001111, 0, 1, 'h44, 0, '0, 3, 0, 0);
    step(0, 6'b000000, 0, 1, 'h5, 1, 'h5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage core; replaces hand-written per-stage registers (if_id, id_ex, ex_mem, ...).
- Carries a packed payload plus a valid bit between two stages.
- Honours the global stall vector, inserts bubbles when upstream stalls and downstream runs, and supports a branch/jump flush.
- Provides a status code and saturating bubble/hold counters for performance monitoring.

Parameters:
DATA_W, 140, payload width in bits (packed stage payload)
STALL_W, 6, width of global stall vector
STAGE_IDX, 2, index of upstream stage's stall bit; downstream bit is STAGE_IDX+1; legal range 0..STALL_W-2
NOP_VALUE, {DATA_W{1'b0}}, payload driven on reset, bubble and flush (must encode NOP inst type, write disable, zero reg addr)
CNT_W, 16, width of performance counters

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous reset, active high
stall  input  STALL_W  global stall vector; 1 = Stop
flush_in  input  1  kill the in-flight instruction (branch mispredict / jump)
valid_in  input  1  upstream payload valid
data_in  input  DATA_W  upstream payload
valid_out  output  1  registered valid to downstream
data_out  output  DATA_W  registered payload to downstream
state_out  output  2  last-cycle action: 0 LOAD, 1 HOLD, 2 BUBBLE, 3 FLUSH
bubble_cnt_out  output  CNT_W  saturating count of bubbles inserted
hold_cnt_out  output  CNT_W  saturating count of consecutive HOLD cycles; cleared on any non-HOLD action

Behaviour:
- Single clock; all outputs registered; reset synchronous, active high.
- Reset: valid_out=0, data_out=NOP_VALUE, state_out=FLUSH(3), bubble_cnt_out=0, hold_cnt_out=0.
- Let up=stall[STAGE_IDX], dn=stall[STAGE_IDX+1]. Per-edge action, strict priority:
  1. rst_in=1 -> reset values, ignores every other input.
  2. flush_in=1 and dn=0 -> FLUSH: valid_out=0, data_out=NOP_VALUE, hold_cnt=0.
  3. up=1 and dn=0 -> BUBBLE: valid_out=0, data_out=NOP_VALUE, bubble_cnt+=1 (saturating at 2^CNT_W-1), hold_cnt=0.
  4. up=0 and dn=0 -> LOAD: valid_out=valid_in, data_out=data_in (payload loaded even when valid_in=0), hold_cnt=0.
  5. dn=1 -> HOLD: valid_out and data_out unchanged, hold_cnt+=1 (saturating).
- The stall vector is monotone: up=0, dn=1 is illegal and is treated as HOLD. An optional assertion flags it.
- Flush while dn=1 is deferred. A flush_latched flag is set and performs the FLUSH action on the first edge with dn=0, taking priority over BUBBLE and LOAD in that cycle. The flag clears then or on reset; a new flush_in while the flag is pending is absorbed. flush_latched is internal and is not an output.
- Latency: one cycle from data_in to data_out on LOAD; zero combinational paths from inputs to outputs.
- Counters never wrap. bubble_cnt is cleared only by reset.
- Reset mid-HOLD or mid-pending-flush discards all state.

Test Plan:
- Reset: assert rst_in 2 cycles with data_in=0xABC, valid_in=1, stall=0 -> valid_out=0, data_out=NOP_VALUE, state_out=3, both counters 0.
- LOAD stream: stall=0, valid_in=1, data_in=1,2,3 on successive edges -> data_out=1,2,3 one cycle later each, valid_out=1, state_out=0.
- Bubble (STAGE_IDX=2): stall=6'b000111 for 3 cycles -> valid_out=0, data_out=NOP_VALUE, state_out=2, bubble_cnt_out=3; release -> next data_in loads.
- Hold: data_out=0x55 then stall=6'b001111 for 4 cycles -> data_out stays 0x55, state_out=1, hold_cnt_out=1,2,3,4; after release hold_cnt_out=0.
- Deferred flush: during HOLD pulse flush_in 1 cycle, then release stall with valid_in=1, data_in=0x77 -> first edge after release gives state_out=3, valid_out=0; next edge loads 0x77.
- Saturation: CNT_W=2, 5 bubble cycles -> bubble_cnt_out=3 and stays 3; illegal stall=6'b001000 -> HOLD behaviour.
